regfile_mp_bypass: RTL
======================

Name: regfile_mp_bypass

Overview:
- Parametrised successor to the dual-read/single-write register file.
- Single clock domain, no 2x clock. NUM_RD read ports, two write ports, and write-to-read bypass.
- Adds an optional hardwired-zero register and a per-register pending scoreboard for hazard detection.
- Sits between decode (read/set-pending) and writeback (two retire lanes) in the pipeline.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH.
- NUM_RD, 2, number of read ports (1..8).
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never pending.

Ports:
- iClk  in  1  clock; all state updates on the rising edge.
- iRst  in  1  reset; synchronous, active-high.
- iAddrRd  in  NUM_RD*ADDR_WIDTH  read addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- iEnRd  in  NUM_RD  per-port read enable.
- oDataRd  out  NUM_RD*DATA_WIDTH  registered read data; port k occupies [k*DATA_WIDTH +: DATA_WIDTH].
- oPendRd  out  NUM_RD  registered pending flag of the address read on port k.
- iEnWr0 / iAddrWr0 / iDataWr0  in  1 / ADDR_WIDTH / DATA_WIDTH  write lane 0.
- iEnWr1 / iAddrWr1 / iDataWr1  in  1 / ADDR_WIDTH / DATA_WIDTH  write lane 1; priority over lane 0.
- iSetPend  in  1  mark register iAddrPend as pending (producer issued).
- iAddrPend  in  ADDR_WIDTH  scoreboard set address.
- oPendCount  out  ADDR_WIDTH+1  number of registers currently pending (registered).

Behaviour:
- Reset (iRst=1 at a rising edge):
  - all registers <= 0, all pending bits <= 0;
  - oDataRd <= 0, oPendRd <= 0, oPendCount <= 0;
  - writes, reads and set-pend are ignored in that cycle.
  - A reset mid-operation discards in-flight pending state; no recovery.
- Write:
  - at the edge, lane with iEnWrX=1 stores iDataWrX at iAddrWrX.
  - Both lanes enabled on the same address: lane 1 data is stored.
  - If ZERO_REG=1 and the address is 0: no store.
- Read, latency 1:
  - if iEnRd[k]=1 at edge N, oDataRd[k] is valid after edge N and holds until the next enabled read or reset.
  - iEnRd[k]=0: oDataRd[k] and oPendRd[k] hold.
- Bypass:
  - read value = lane 1 data if iEnWr1 and iAddrWr1==addr;
  - else lane 0 data if iEnWr0 and iAddrWr0==addr;
  - else the array value.
  - Result: a same-cycle write is visible with no stall.
  - ZERO_REG=1 and addr==0 gives 0 regardless of bypass.
- Scoreboard next-state per register r:
  - pend_n[r] = (pend[r] & ~wr_hit[r]) | set_hit[r];
  - wr_hit[r] = any enabled lane writes r;
  - set_hit[r] = iSetPend & iAddrPend==r.
  - Set and write to the same register in one cycle: set wins (new producer), so the register remains pending.
  - ZERO_REG=1: pend[0] is forced 0.
- oPendRd[k] <= pend_n[addr_k] when iEnRd[k]=1. It reflects the post-edge state, consistent with bypassed data.
- oPendCount <= popcount(pend_n), range 0..2**ADDR_WIDTH, hence width ADDR_WIDTH+1. No wrap: a set on an already-pending register does not increment it.
- All read ports are independent. Duplicate addresses across ports return identical data and flags.
- No combinational path from any input to any output.

Test Plan:
- Reset: iRst=1 one cycle with iEnWr0=1 addr 3 data 0xDEAD -> next cycle read addr 3 gives oDataRd=0, oPendCount=0.
- Write then read: write lane0 addr 5 0x12345678 at edge N; read port1 addr 5 at edge N+1 -> oDataRd[1]=0x12345678 after N+1.
- Bypass/priority: same edge lane0 addr 7 0xAAAA_AAAA, lane1 addr 7 0x5555_5555, port0 reads addr 7 -> oDataRd[0]=0x5555_5555 after that edge; a later read of addr 7 gives 0x5555_5555.
- Zero register (ZERO_REG=1): write addr 0 0xFFFF_FFFF plus iSetPend addr 0 -> read addr 0 gives 0, oPendRd=0, oPendCount=0.
- Scoreboard:
  - iSetPend addr 9 -> oPendCount=1; read addr 9 -> oPendRd=1;
  - repeated set addr 9 -> count stays 1;
  - lane0 write addr 9 -> count=0;
  - set and write addr 9 in the same cycle -> count=1, oPendRd=1.
- Read hold (NUM_RD=4): enable port 2 only, addr 5 -> ports 0, 1 and 3 keep their prior values; port 2 updates.

Source files
------------

// File: rtl/regfile_mp_bypass.sv
// regfile_mp_bypass: multi-read, dual-write register file with write bypass and pending scoreboard
module regfile_mp_bypass #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                         iClk,
  input  logic                         iRst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] iAddrRd,
  input  logic [NUM_RD-1:0]            iEnRd,
  output logic [NUM_RD*DATA_WIDTH-1:0] oDataRd,
  output logic [NUM_RD-1:0]            oPendRd,
  input  logic                         iEnWr0,
  input  logic [ADDR_WIDTH-1:0]        iAddrWr0,
  input  logic [DATA_WIDTH-1:0]        iDataWr0,
  input  logic                         iEnWr1,
  input  logic [ADDR_WIDTH-1:0]        iAddrWr1,
  input  logic [DATA_WIDTH-1:0]        iDataWr1,
  input  logic                         iSetPend,
  input  logic [ADDR_WIDTH-1:0]        iAddrPend,
  output logic [ADDR_WIDTH:0]          oPendCount
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pend, pend_n;
  logic [ADDR_WIDTH:0] cnt_n;
  logic [DATA_WIDTH-1:0] rd_val [NUM_RD];
  logic [NUM_RD-1:0] rd_pnd;
  logic wr0_ok, wr1_ok;

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] a);
    return ZERO_REG != 0 && a == '0;
  endfunction

  assign wr0_ok = iEnWr0 && !is_zero(iAddrWr0);
  assign wr1_ok = iEnWr1 && !is_zero(iAddrWr1);

  // a set in the same cycle as a retire wins: a new producer has been issued
  always_comb begin
    pend_n = pend;
    if (iEnWr0) pend_n[iAddrWr0] = 1'b0;
    if (iEnWr1) pend_n[iAddrWr1] = 1'b0;
    if (iSetPend) pend_n[iAddrPend] = 1'b1;
    if (ZERO_REG != 0) pend_n[0] = 1'b0;
  end

  always_comb begin
    cnt_n = '0;
    for (int r = 0; r < DEPTH; r++) cnt_n = cnt_n + {{ADDR_WIDTH{1'b0}}, pend_n[r]};
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    assign a = iAddrRd[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign rd_val[k] = is_zero(a) ? '0 :
                       (iEnWr1 && iAddrWr1 == a) ? iDataWr1 :
                       (iEnWr0 && iAddrWr0 == a) ? iDataWr0 : mem[a];
    assign rd_pnd[k] = pend_n[a];
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
      pend <= '0;
      oDataRd <= '0;
      oPendRd <= '0;
      oPendCount <= '0;
    end else begin
      if (wr0_ok) mem[iAddrWr0] <= iDataWr0;
      if (wr1_ok) mem[iAddrWr1] <= iDataWr1;
      pend <= pend_n;
      oPendCount <= cnt_n;
      for (int k = 0; k < NUM_RD; k++) begin
        if (iEnRd[k]) begin
          oDataRd[k*DATA_WIDTH +: DATA_WIDTH] <= rd_val[k];
          oPendRd[k] <= rd_pnd[k];
        end
      end
    end
  end
endmodule
